// File: rtl/pb_debounce_multi.sv
`default_nettype none
// ============================================================================
// pb_debounce_multi : N-channel push-button debouncer with shared sample tick,
//                     clean level and one-clk rise/fall pulses per channel.
//                     Define DEBOUNCE_REPEAT_EN for per-channel auto-repeat.
// Revision: 1.0  initial release
// ============================================================================
module pb_debounce_multi #(
   parameter int   N_CH         = 4,
   parameter int   TICK_DIV     = 50000,
   parameter int   STABLE_TICKS = 8,
   parameter logic INIT_LEVEL   = 1'b0,
   parameter int   HOLD_TICKS   = 500,
   parameter int   REPEAT_TICKS = 100
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] button,
   output logic [N_CH-1:0] db_level,
   output logic [N_CH-1:0] db_rise,
   output logic [N_CH-1:0] db_fall,
   output logic [N_CH-1:0] db_repeat,
   output logic            tick
);

   localparam int                 c_pre_w    = $clog2(TICK_DIV + 1);
   localparam int                 c_cnt_w    = $clog2(STABLE_TICKS + 1);
   localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_TICKS - 1);
   localparam logic [N_CH-1:0]    c_init     = {N_CH{INIT_LEVEL}};

   generate
      if (N_CH < 1 || TICK_DIV < 1 || STABLE_TICKS < 1 ||
          HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_bad_cfg
         $error("pb_debounce_multi: parameter out of range");
      end
   endgenerate

   logic [c_pre_w-1:0] r_pre;
   logic               r_tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_pre == c_pre_last);
         if (r_pre == c_pre_last)
            r_pre <= '0;
         else
            r_pre <= r_pre + 1'b1;
      end
   end

   assign tick = r_tick;

   // Two synchronizer flops plus one retiming stage that feeds the qualifier.
   logic [N_CH-1:0] r_ff1, r_ff2, r_smp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ff1 <= c_init;
         r_ff2 <= c_init;
         r_smp <= c_init;
      end else begin
         r_ff1 <= button;
         r_ff2 <= r_ff1;
         r_smp <= r_ff2;
      end
   end

   logic [N_CH-1:0] w_accept;

   generate
      for (genvar i = 0; i < N_CH; i++) begin : g_ch
         logic [c_cnt_w-1:0] r_cnt;
         logic               r_level;
         logic               r_rise;
         logic               r_fall;
         logic               w_diff;

         assign w_diff      = r_smp[i] ^ r_level;
         assign w_accept[i] = r_tick & w_diff & (r_cnt == c_cnt_last);

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt   <= '0;
               r_level <= INIT_LEVEL;
               r_rise  <= 1'b0;
               r_fall  <= 1'b0;
            end else begin
               r_rise <= w_accept[i] &  r_smp[i];
               r_fall <= w_accept[i] & ~r_smp[i];
               if (r_tick) begin
                  // An agreeing sample restarts qualification from zero.
                  if (!w_diff || w_accept[i])
                     r_cnt <= '0;
                  else
                     r_cnt <= r_cnt + 1'b1;
                  if (w_accept[i])
                     r_level <= r_smp[i];
               end
            end
         end

         assign db_level[i] = r_level;
         assign db_rise[i]  = r_rise;
         assign db_fall[i]  = r_fall;

`ifdef DEBOUNCE_REPEAT_EN
         localparam int c_hold_w =
            $clog2(((HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS) + 1);
         localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_TICKS - 1);
         localparam logic [c_hold_w-1:0] c_rep_last  = c_hold_w'(REPEAT_TICKS - 1);

         logic [c_hold_w-1:0] r_hold;
         logic                r_armed;
         logic                r_rep;
         logic [c_hold_w-1:0] w_hold_last;

         assign w_hold_last = r_armed ? c_rep_last : c_hold_last;

         // Counter reloads after each pulse, so it never passes its target.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_hold  <= '0;
               r_armed <= 1'b0;
               r_rep   <= 1'b0;
            end else begin
               r_rep <= 1'b0;
               if (!r_level || w_accept[i]) begin
                  r_hold  <= '0;
                  r_armed <= 1'b0;
               end else if (r_tick) begin
                  if (r_hold == w_hold_last) begin
                     r_rep   <= 1'b1;
                     r_hold  <= '0;
                     r_armed <= 1'b1;
                  end else begin
                     r_hold <= r_hold + 1'b1;
                  end
               end
            end
         end

         assign db_repeat[i] = r_rep;
`else
         assign db_repeat[i] = 1'b0;
`endif
      end
   endgenerate

endmodule
`default_nettype wire
